// File: rtl/ball_engine.sv
// Pong ball engine: fixed-point position integration driven by registered sin/cos
// lookups, with serve/play/hold sequencing, wall and paddle reflection, and miss detection.

module ball_engine_sin #(
    parameter int TW = 6
) (
    input  logic              clk,
    input  logic [TW-1:0]     theta,
    output logic signed [7:0] val
);
    logic [5:0] a;
    logic [4:0] k;
    logic [6:0] mag;
    logic [7:0] m8;

    // Table is built for 64 steps per turn; other resolutions map onto it.
    generate
        if (TW >= 6) begin : g_trunc
            assign a = theta[TW-1 -: 6];
        end else begin : g_pad
            assign a = {theta, {(6-TW){1'b0}}};
        end
    endgenerate

    function automatic logic [6:0] qtab(input logic [4:0] i);
        case (i)
            5'd0:  qtab = 7'd0;   5'd1:  qtab = 7'd12;  5'd2:  qtab = 7'd25;
            5'd3:  qtab = 7'd37;  5'd4:  qtab = 7'd49;  5'd5:  qtab = 7'd60;
            5'd6:  qtab = 7'd71;  5'd7:  qtab = 7'd81;  5'd8:  qtab = 7'd90;
            5'd9:  qtab = 7'd98;  5'd10: qtab = 7'd106; 5'd11: qtab = 7'd112;
            5'd12: qtab = 7'd117; 5'd13: qtab = 7'd122; 5'd14: qtab = 7'd125;
            5'd15: qtab = 7'd126; default: qtab = 7'd127;
        endcase
    endfunction

    always_comb begin
        k   = a[4] ? (5'd16 - {1'b0, a[3:0]}) : {1'b0, a[3:0]};
        mag = qtab(k);
        m8  = {1'b0, mag};
    end

    always_ff @(posedge clk)
        val <= a[5] ? $signed(-m8) : $signed(m8);
endmodule

module ball_engine #(
    parameter int POS_BITS    = 4,
    parameter int FRAC_BITS   = 12,
    parameter int THETA_WIDTH = 6,
    parameter int SPEED_WIDTH = 5,
    parameter int PADDLE_LEN  = 4,
    parameter int HOLD_TICKS  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   serve,
    input  logic [THETA_WIDTH-1:0] serve_theta,
    input  logic [SPEED_WIDTH-1:0] speed,
    input  logic [POS_BITS-1:0]    paddle_l,
    input  logic [POS_BITS-1:0]    paddle_r,
    output logic [POS_BITS-1:0]    x,
    output logic [POS_BITS-1:0]    y,
    output logic [THETA_WIDTH-1:0] theta,
    output logic                   in_play,
    output logic                   wall_hit,
    output logic                   paddle_hit,
    output logic                   miss_l,
    output logic                   miss_r
);
    localparam int P  = POS_BITS + FRAC_BITS;
    localparam int D  = 8 + SPEED_WIDTH;
    localparam int CW = $clog2(HOLD_TICKS) + 1;
    localparam logic [P-1:0]           CENTRE    = {1'b1, {(P-1){1'b0}}};
    localparam logic [P-1:0]           PMAX      = '1;
    localparam logic [THETA_WIDTH-1:0] QTR       = {2'b01, {(THETA_WIDTH-2){1'b0}}};
    localparam logic [THETA_WIDTH-1:0] HALF      = {2'b10, {(THETA_WIDTH-2){1'b0}}};
    localparam logic [POS_BITS:0]      PLEN_M1   = (POS_BITS+1)'(PADDLE_LEN - 1);
    localparam logic [CW-1:0]          HOLD_LAST = CW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, MOVE, HOLD} state_t;

    state_t                   state, state_n;
    logic [P-1:0]             h, v, h_n, v_n, v_clamp;
    logic [THETA_WIDTH-1:0]   theta_n, t_vref, theta_cos;
    logic                     settle, settle_n;
    logic [CW-1:0]            cnt, cnt_n;
    logic                     wall_n, paddle_n, miss_l_n, miss_r_n;
    logic signed [7:0]        sin_v, cos_v;
    logic signed [D-1:0]      dx, dy;
    logic signed [P:0]        sum_h, sum_v;
    logic                     h_under, h_over, v_under, v_over, on_pad;
    logic [POS_BITS:0]        y_new, pad_top;

    assign theta_cos = theta + QTR;

    ball_engine_sin #(.TW(THETA_WIDTH)) u_sin (.clk(clk), .theta(theta),     .val(sin_v));
    ball_engine_sin #(.TW(THETA_WIDTH)) u_cos (.clk(clk), .theta(theta_cos), .val(cos_v));

    assign dx = $signed({{SPEED_WIDTH{cos_v[7]}}, cos_v}) * $signed({{8{speed[SPEED_WIDTH-1]}}, speed});
    assign dy = $signed({{SPEED_WIDTH{sin_v[7]}}, sin_v}) * $signed({{8{speed[SPEED_WIDTH-1]}}, speed});
    assign sum_h = $signed({1'b0, h}) + $signed({{(P+1-D){dx[D-1]}}, dx});
    assign sum_v = $signed({1'b0, v}) + $signed({{(P+1-D){dy[D-1]}}, dy});

    // The step is tiny versus the range, so bit P means "below 0" for a negative
    // step and "at or above 2^P" for a positive one.
    assign h_under = dx[D-1]  & sum_h[P];
    assign h_over  = ~dx[D-1] & sum_h[P];
    assign v_under = dy[D-1]  & sum_v[P];
    assign v_over  = ~dy[D-1] & sum_v[P];

    assign v_clamp = v_under ? '0 : (v_over ? PMAX : sum_v[P-1:0]);
    assign y_new   = {1'b0, v_clamp[P-1 -: POS_BITS]};
    assign pad_top = {1'b0, h_under ? paddle_l : paddle_r};
    assign on_pad  = (y_new >= pad_top) && (y_new <= pad_top + PLEN_M1);

    always_comb begin
        state_n  = state;
        h_n      = h;
        v_n      = v;
        theta_n  = theta;
        t_vref   = theta;
        settle_n = 1'b0;
        cnt_n    = cnt;
        wall_n   = 1'b0;
        paddle_n = 1'b0;
        miss_l_n = 1'b0;
        miss_r_n = 1'b0;
        case (state)
            IDLE: begin
                h_n   = CENTRE;
                v_n   = CENTRE;
                cnt_n = '0;
                if (serve) begin
                    theta_n = serve_theta;
                    state_n = SETTLE;
                end
            end
            SETTLE: state_n = MOVE;
            MOVE: begin
                if (tick && !settle) begin
                    if ((h_under || h_over) && !on_pad) begin
                        miss_l_n = h_under;
                        miss_r_n = h_over;
                        state_n  = HOLD;
                    end else begin
                        h_n      = h_under ? '0 : (h_over ? PMAX : sum_h[P-1:0]);
                        v_n      = v_clamp;
                        t_vref   = (v_under || v_over) ? -theta : theta;
                        theta_n  = (h_under || h_over) ? HALF - t_vref : t_vref;
                        wall_n   = v_under || v_over;
                        paddle_n = h_under || h_over;
                        // LUTs need a cycle to follow the new angle.
                        settle_n = (theta_n != theta);
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (cnt == HOLD_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        h_n     = CENTRE;
                        v_n     = CENTRE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            h          <= CENTRE;
            v          <= CENTRE;
            theta      <= '0;
            settle     <= 1'b0;
            cnt        <= '0;
            wall_hit   <= 1'b0;
            paddle_hit <= 1'b0;
            miss_l     <= 1'b0;
            miss_r     <= 1'b0;
        end else begin
            state      <= state_n;
            h          <= h_n;
            v          <= v_n;
            theta      <= theta_n;
            settle     <= settle_n;
            cnt        <= cnt_n;
            wall_hit   <= wall_n;
            paddle_hit <= paddle_n;
            miss_l     <= miss_l_n;
            miss_r     <= miss_r_n;
        end
    end

    assign x       = h[P-1 -: POS_BITS];
    assign y       = v[P-1 -: POS_BITS];
    assign in_play = (state == SETTLE) || (state == MOVE);
endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: directed test-plan scenarios plus random play, all
// compared every cycle against a trigonometric reference model.
`timescale 1ns/1ps
module tb_ball_engine;
    localparam int PB = 4, FB = 12, TW = 6, SW = 5, PL = 4, HT = 8;
    localparam int PMAXI = (1 << (PB + FB)) - 1;
    localparam int CEN   = 1 << (PB + FB - 1);
    localparam int M_IDLE = 0, M_SETTLE = 1, M_MOVE = 2, M_HOLD = 3;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic reset, tick, serve;
    logic [TW-1:0] serve_theta;
    logic [SW-1:0] speed;
    logic [PB-1:0] paddle_l, paddle_r;
    logic [PB-1:0] x, y;
    logic [TW-1:0] theta;
    logic in_play, wall_hit, paddle_hit, miss_l, miss_r;

    ball_engine #(.POS_BITS(PB), .FRAC_BITS(FB), .THETA_WIDTH(TW), .SPEED_WIDTH(SW),
                  .PADDLE_LEN(PL), .HOLD_TICKS(HT)) dut (
        .clk(clk), .reset(reset), .tick(tick), .serve(serve), .serve_theta(serve_theta),
        .speed(speed), .paddle_l(paddle_l), .paddle_r(paddle_r), .x(x), .y(y),
        .theta(theta), .in_play(in_play), .wall_hit(wall_hit), .paddle_hit(paddle_hit),
        .miss_l(miss_l), .miss_r(miss_r));

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int mh, mv, mth, mode, mcnt;
    bit mset, mw, mp, mml, mmr;

    function automatic int msin(input int t);
        real r;
        r = 127.0 * $sin(2.0 * PI * real'(t) / 64.0);
        return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
    endfunction

    task automatic mstep();
        int spd, dx, dy, sh, sv, vc, yn, pd, nt;
        bit hu, ho, vu, vo, on;
        spd = int'($signed(speed));
        dx = msin(mth + 16) * spd;
        dy = msin(mth) * spd;
        sh = mh + dx;  sv = mv + dy;
        hu = sh < 0;   ho = sh > PMAXI;
        vu = sv < 0;   vo = sv > PMAXI;
        vc = vu ? 0 : (vo ? PMAXI : sv);
        yn = vc >> FB;
        pd = hu ? int'(paddle_l) : int'(paddle_r);
        on = (yn >= pd) && (yn <= pd + PL - 1);
        if ((hu || ho) && !on) begin
            mml = hu; mmr = ho; mode = M_HOLD; mcnt = 0;
        end else begin
            nt = mth;
            if (vu || vo) nt = (64 - nt) % 64;
            if (hu || ho) nt = ((32 - nt) % 64 + 64) % 64;
            mh = hu ? 0 : (ho ? PMAXI : sh);
            mv = vc;
            mw = vu || vo;
            mp = hu || ho;
            mset = (nt != mth);
            mth = nt;
        end
    endtask

    always @(posedge clk) begin
        bit blocked;
        mw = 0; mp = 0; mml = 0; mmr = 0;
        if (reset) begin
            mode = M_IDLE; mh = CEN; mv = CEN; mth = 0; mset = 0; mcnt = 0;
        end else begin
            case (mode)
                M_IDLE: begin
                    mh = CEN; mv = CEN;
                    if (serve) begin mth = int'(serve_theta); mode = M_SETTLE; end
                end
                M_SETTLE: mode = M_MOVE;
                M_MOVE: begin
                    blocked = mset;
                    mset = 0;
                    if (tick && !blocked) mstep();
                end
                default: if (tick) begin
                    mcnt++;
                    if (mcnt == HT) begin mode = M_IDLE; mh = CEN; mv = CEN; mcnt = 0; end
                end
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("x", x, mh >> FB);
            chk("y", y, mv >> FB);
            chk("theta", theta, mth);
            chk("in_play", in_play, (mode == M_SETTLE || mode == M_MOVE));
            chk("wall_hit", wall_hit, mw);
            chk("paddle_hit", paddle_hit, mp);
            chk("miss", {miss_l, miss_r}, {mml, mmr});
        end
    end

    // ---------------- stimulus ----------------
    task automatic reset_dut();
        reset = 1; @(negedge clk); reset = 0;
    endtask

    task automatic ticks(input int n, input int gap);
        repeat (n) begin
            tick = 1; @(negedge clk); tick = 0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic do_serve(input int th);
        serve_theta = TW'(th); serve = 1; @(negedge clk); serve = 0;
    endtask

    initial begin
        reset = 1; tick = 0; serve = 0; serve_theta = '0; speed = '0;
        paddle_l = '0; paddle_r = '0;
        @(negedge clk); @(negedge clk);
        reset = 0;
        chk_en = 1;

        // Reset state and idle ticks
        chk("rst_x", x, 8); chk("rst_y", y, 8); chk("rst_theta", theta, 0); chk("rst_in_play", in_play, 0);
        ticks(20, 1);
        chk("idle_x", x, 8); chk("idle_y", y, 8);

        // Right paddle hit, with a tick dropped in SETTLE and after the reflection
        paddle_l = 0; paddle_r = 6; speed = 8;
        do_serve(0);
        tick = 1; @(negedge clk); tick = 0;
        chk("settle_drop_h", dut.h, 16'h8000); chk("settle_in_play", in_play, 1);
        ticks(32, 4);
        chk("hit_h32", dut.h, 16'hFF00); chk("model_h32", mh, 16'hFF00);
        ticks(1, 1);
        chk("hit_h33", dut.h, 16'hFFFF); chk("hit_theta", theta, 32); chk("hit_pulse", paddle_hit, 1);
        ticks(1, 1);
        chk("refl_drop_h", dut.h, 16'hFFFF); chk("refl_pulse_gone", paddle_hit, 0);

        // Right miss, hold, stray serve
        reset_dut();
        paddle_r = 0;
        do_serve(0);
        @(negedge clk);
        ticks(32, 4);
        ticks(1, 1);
        chk("miss_r", miss_r, 1); chk("miss_x", x, 15); chk("miss_in_play", in_play, 0);
        do_serve(5);
        chk("hold_serve_ign", in_play, 0); chk("hold_theta", theta, 0);
        ticks(7, 2);
        chk("hold_x", x, 15);
        ticks(1, 1);
        chk("hold_end_x", x, 8); chk("hold_end_y", y, 8);
        do_serve(0);
        chk("idle_again", in_play, 1);

        // Bottom wall, then mid-play reset with serve and tick
        reset_dut();
        do_serve(16);
        @(negedge clk);
        ticks(32, 4);
        ticks(1, 1);
        chk("wall_v", dut.v, 16'hFFFF); chk("wall_theta", theta, 48); chk("wall_pulse", wall_hit, 1);
        @(negedge clk);
        ticks(5, 2);
        chk("wall_y_back", y, 14); chk("model_v_back", mv, 60455);
        reset = 1; serve = 1; tick = 1;
        @(negedge clk);
        reset = 0; serve = 0; tick = 0;
        chk("mid_rst_x", x, 8); chk("mid_rst_y", y, 8); chk("mid_rst_in_play", in_play, 0);
        chk("mid_rst_theta", theta, 0); chk("mid_rst_pulses", {wall_hit, paddle_hit, miss_l, miss_r}, 0);
        serve_theta = 0; speed = 8; serve = 1; tick = 1;
        @(negedge clk);
        serve = 0; tick = 0;
        chk("serve_tick_h", dut.h, 16'h8000); chk("serve_tick_play", in_play, 1);

        // Random play
        for (int i = 0; i < 20000; i++) begin
            reset = ($urandom_range(2999) == 0);
            serve = ($urandom_range(7) == 0);
            serve_theta = TW'($urandom);
            speed = SW'($urandom);
            tick = $urandom_range(1);
            if ($urandom_range(40) == 0) begin
                paddle_l = PB'($urandom); paddle_r = PB'($urandom);
            end
            @(negedge clk);
        end
        reset = 0; serve = 0; tick = 0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
